// File: rtl/mem_access_ctrl_pkg.sv
// Shared memory-stage definitions: FSM encoding, lane-enable constants and
// the control-bit positions used by the pipeline registers.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_LANE0 = 4'b0001;

  localparam int CTRL_MEM_READ  = 2;
  localparam int CTRL_MEM_WRITE = 4;
  localparam int CTRL_REG_WRITE = 6;
  localparam int CTRL_WORD      = 8;

  function automatic logic [3:0] byte_en(input logic word, input logic [1:0] lane);
    return word ? BE_WORD : (BE_LANE0 << lane);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Combinational load aligner: picks the little-endian byte lane and extends it,
// or passes a full word through untouched.
module mem_access_ctrl_load_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic        word,
  input  logic        signExt,
  output logic [31:0] data
);

  logic [7:0] lane_byte;

  always_comb begin
    lane_byte = rdata[7:0];
    case (lane)
      2'd0: lane_byte = rdata[7:0];
      2'd1: lane_byte = rdata[15:8];
      2'd2: lane_byte = rdata[23:16];
      2'd3: lane_byte = rdata[31:24];
      default: lane_byte = rdata[7:0];
    endcase
    if (word) data = rdata;
    else      data = {{24{signExt & lane_byte[7]}}, lane_byte};
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: issues one request/ready data-memory access per EX/MEM op,
// stalling upstream from issue until the memory answers (or times out); result one cycle later.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT       = 64,
  parameter int SIGN_EXT_BYTE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        word,
  input  logic        flushPrev,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memByteEn,
  input  logic        memReady,
  input  logic [31:0] memRdata,
  output logic        stall,
  output logic [31:0] loadData,
  output logic        loadValid,
  output logic        misalign,
  output logic        busErr
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic SEXT = (SIGN_EXT_BYTE != 0);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_load;
  logic          word_q;
  logic [1:0]    lane_q;
  logic [31:0]   aligned;

  logic pending;
  logic unaligned;

  assign pending   = (memRead | memWrite) & ~flushPrev;
  assign unaligned = word & (address[1:0] != 2'b00);
  // Stall must rise in the issue cycle itself so EX/MEM holds the op.
  assign stall     = (state == REQ) | ((state == IDLE) & pending & ~unaligned);

  mem_access_ctrl_load_align u_align (
    .rdata   (memRdata),
    .lane    (lane_q),
    .word    (word_q),
    .signExt (SEXT),
    .data    (aligned)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWdata  <= '0;
      memByteEn <= BE_NONE;
      loadData  <= '0;
      loadValid <= 1'b0;
      misalign  <= 1'b0;
      busErr    <= 1'b0;
      is_load   <= 1'b0;
      word_q    <= 1'b0;
      lane_q    <= 2'd0;
    end else begin
      misalign  <= 1'b0;
      loadValid <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            if (unaligned) begin
              misalign <= 1'b1;
            end else begin
              // A simultaneous read+write is treated as a store.
              memReq    <= 1'b1;
              memWe     <= memWrite;
              memAddr   <= {address[31:2], 2'b00};
              memWdata  <= word ? storeData : {4{storeData[7:0]}};
              memByteEn <= byte_en(word, address[1:0]);
              is_load   <= ~memWrite;
              word_q    <= word;
              lane_q    <= address[1:0];
              cnt       <= '0;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          cnt <= cnt + CNT_ONE;
          if (memReady) begin
            memReq    <= 1'b0;
            loadValid <= is_load;
            if (is_load) loadData <= aligned;
            state     <= DONE;
          end else if (cnt == CNT_LAST) begin
            memReq    <= 1'b0;
            busErr    <= 1'b1;
            loadData  <= '0;
            loadValid <= is_load;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: stimulus queues expected requests/loads,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        memRead, memWrite, word, flushPrev;
  logic [31:0] address, storeData;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWdata;
  logic [3:0]  memByteEn;
  logic        memReady;
  logic [31:0] memRdata;
  logic        stall;
  logic [31:0] loadData;
  logic        loadValid, misalign, busErr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] load_q[$];
  int          mis_q[$];
  req_t        cur;
  logic        prev_req = 1'b0;

  mem_access_ctrl #(.TIMEOUT(8), .SIGN_EXT_BYTE(1)) dut (
    .clock(clock), .reset(reset),
    .memRead(memRead), .memWrite(memWrite), .word(word), .flushPrev(flushPrev),
    .address(address), .storeData(storeData),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memByteEn(memByteEn), .memReady(memReady), .memRdata(memRdata),
    .stall(stall), .loadData(loadData), .loadValid(loadValid),
    .misalign(misalign), .busErr(busErr)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected DUT output", name);
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (memReq && !prev_req) begin
      if (req_q.size() == 0) flag("req_unexpected");
      else begin
        cur = req_q.pop_front();
        check("req_addr", memAddr, cur.addr);
        check("req_be", {28'd0, memByteEn}, {28'd0, cur.be});
        check("req_we", {31'd0, memWe}, {31'd0, cur.we});
        check("req_wdata", memWdata, cur.wdata);
      end
    end else if (memReq) begin
      check("req_addr_stable", memAddr, cur.addr);
      check("req_wdata_stable", memWdata, cur.wdata);
    end
    prev_req = memReq;
    if (loadValid) begin
      if (load_q.size() == 0) flag("load_unexpected");
      else check("load_data", loadData, load_q.pop_front());
    end
    if (misalign) begin
      if (mis_q.size() == 0) flag("misalign_unexpected");
      else void'(mis_q.pop_front());
    end
  end

  task automatic clear_inputs();
    memRead = 0; memWrite = 0; word = 0; flushPrev = 0;
    address = '0; storeData = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one op; k = cycle offset of memReady (0 = never). Returns REQ cycle count.
  task automatic access(input logic rd, input logic wr, input logic wd,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rdata, input int k, output int req_cycles);
    memRead = rd; memWrite = wr; word = wd; flushPrev = 0;
    address = addr; storeData = sd;
    #1;
    check("stall_issue", {31'd0, stall}, 32'd1);
    tick();
    req_cycles = 0;
    for (int j = 1; j <= 100; j++) begin
      if (k != 0 && j == k) begin
        memReady = 1; memRdata = rdata;
      end
      check("stall_req", {31'd0, stall}, 32'd1);
      tick();
      memReady = 0;
      req_cycles = j;
      if (!memReq) break;
    end
    clear_inputs();
    #1;
    check("stall_done", {31'd0, stall}, 32'd0);
    tick();
  endtask

  int n;

  initial begin
    reset = 1; memReady = 0; memRdata = '0;
    clear_inputs();
    tick(); tick();
    check("rst_memReq", {31'd0, memReq}, 32'd0);
    check("rst_memWe", {31'd0, memWe}, 32'd0);
    check("rst_memAddr", memAddr, 32'd0);
    check("rst_memByteEn", {28'd0, memByteEn}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_loadData", loadData, 32'd0);
    check("rst_loadValid", {31'd0, loadValid}, 32'd0);
    check("rst_busErr", {31'd0, busErr}, 32'd0);
    reset = 0;
    tick();

    // Word load, ready at N+1
    req_q.push_back('{32'h100, 4'b1111, 1'b0, 32'h12345678});
    load_q.push_back(32'hDEADBEEF);
    access(1, 0, 1, 32'h100, 32'h12345678, 32'hDEADBEEF, 1, n);
    check("wload_req_cycles", n, 1);

    // Byte load lane 3, sign-extended
    req_q.push_back('{32'h100, 4'b1000, 1'b0, 32'h0});
    load_q.push_back(32'hFFFFFF80);
    access(1, 0, 0, 32'h103, 32'h0, 32'h80FF0000, 2, n);

    // Byte load lane 1, positive byte, ready at N+3
    req_q.push_back('{32'h100, 4'b0010, 1'b0, 32'h0});
    load_q.push_back(32'h0000007F);
    access(1, 0, 0, 32'h101, 32'h0, 32'h00007F00, 3, n);
    check("bload_req_cycles", n, 3);

    // Byte store, replicated lanes, no loadValid
    req_q.push_back('{32'h200, 4'b0010, 1'b1, 32'hA5A5A5A5});
    access(0, 1, 0, 32'h201, 32'h000000A5, 32'h0, 2, n);

    // Misaligned word store
    memWrite = 1; word = 1; address = 32'h202; storeData = 32'h11112222;
    mis_q.push_back(1);
    #1;
    check("mis_stall", {31'd0, stall}, 32'd0);
    tick();
    clear_inputs();
    check("mis_pulse", {31'd0, misalign}, 32'd1);
    check("mis_memReq", {31'd0, memReq}, 32'd0);
    tick();
    check("mis_pulse_end", {31'd0, misalign}, 32'd0);

    // Read and write together behave as a store
    req_q.push_back('{32'h300, 4'b1111, 1'b1, 32'hCAFEF00D});
    access(1, 1, 1, 32'h300, 32'hCAFEF00D, 32'h55555555, 1, n);

    // Timeout: memReady never comes
    req_q.push_back('{32'h400, 4'b1111, 1'b0, 32'h0});
    load_q.push_back(32'h0);
    access(1, 0, 1, 32'h400, 32'h0, 32'h0, 0, n);
    check("timeout_req_cycles", n, 8);
    check("timeout_busErr", {31'd0, busErr}, 32'd1);

    // Flushed load: pass-through
    memRead = 1; word = 1; flushPrev = 1; address = 32'h500;
    #1;
    check("flush_stall", {31'd0, stall}, 32'd0);
    tick();
    check("flush_memReq", {31'd0, memReq}, 32'd0);
    tick();
    clear_inputs();
    check("busErr_sticky", {31'd0, busErr}, 32'd1);

    // Reset during the third REQ cycle
    req_q.push_back('{32'h600, 4'b1111, 1'b0, 32'h0});
    memRead = 1; word = 1; address = 32'h600;
    tick(); tick(); tick();
    check("rreq_memReq", {31'd0, memReq}, 32'd1);
    reset = 1;
    clear_inputs();
    tick();
    check("rreq_drop", {31'd0, memReq}, 32'd0);
    check("rreq_stall", {31'd0, stall}, 32'd0);
    check("rreq_busErr", {31'd0, busErr}, 32'd0);
    reset = 0;
    memReady = 1; memRdata = 32'h77777777;
    tick();
    memReady = 0;
    check("late_ready_memReq", {31'd0, memReq}, 32'd0);
    check("late_ready_loadValid", {31'd0, loadValid}, 32'd0);
    tick(); tick();

    check("req_q_drained", req_q.size(), 0);
    check("load_q_drained", load_q.size(), 0);
    check("mis_q_drained", mis_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
